ps2_rx_deser: RTL

//  PS/2 device-to-host receiver. Feeds keyb_data/keyb_valid to the keyboard register block (177660/177662).

---
 rtl/ps2_rx_deser.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_deser.sv
// ps2_rx_deser: PS/2 device-to-host receiver.
// Synchronises and deglitches PS2_CLK/PS2_DAT, deserialises 11-bit frames
// (start, 8 data LSB-first, odd parity, stop) and delivers good bytes.
// Bad frames (parity, stop, timeout) are dropped and flagged on rx_err.
// Optional macro PS2_RX_FIFO_EN adds a FIFO_DEPTH-entry first-word-fall-through
// FIFO with keyb_ready backpressure and overflow reporting; FIFO_DEPTH >= 2.
module ps2_rx_deser #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk_bus,
  input  logic       nreset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic       keyb_ready,
  output logic [7:0] keyb_data,
  output logic       keyb_valid,
  output logic       rx_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  localparam logic [7:0]  FILT_MAX = 8'(FILTER_LEN - 1);
  localparam logic [19:0] TO_MAX   = 20'(TIMEOUT_CYC - 1);

  // Line index 0 is the PS/2 clock, index 1 is the PS/2 data.
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_filt;
  logic [7:0] r_fcnt [2];
  logic       r_clk_fd;

  state_t      r_state;
  state_t      w_state_nx;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_sr;
  logic        r_par;
  logic [19:0] r_to_cnt;

  logic w_fall;
  logic w_dat;
  logic w_good;
  logic w_bad;

  // Two-FF synchroniser for both raw lines; idle-high reset value.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_bus or negedge nreset) begin
    if (!nreset) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
    end else begin
      r_sync1 <= {PS2_DAT, PS2_CLK};
      r_sync2 <= r_sync1;
    end
  end

  // Deglitch filter: the filtered line follows only after FILTER_LEN differing samples.
  always_ff @(posedge clk_bus or negedge nreset) begin
    if (!nreset) begin
      r_filt <= 2'b11;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= 8'd0;
        end else if (r_fcnt[i] == FILT_MAX) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= 8'd0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 8'd1;
        end
      end
    end
  end

  // Previous filtered clock, for one-cycle falling-edge detection.
  always_ff @(posedge clk_bus or negedge nreset) begin
    if (!nreset) r_clk_fd <= 1'b1;
    else         r_clk_fd <= r_filt[0];
  end

  assign w_fall = r_clk_fd & ~r_filt[0];
  assign w_dat  = r_filt[1];

  // Frame FSM next state plus good/bad frame decisions; a fall beats a timeout.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nx = r_state;
    w_good     = 1'b0;
    w_bad      = 1'b0;
    if (w_fall) begin
      case (r_state)
        ST_IDLE:   if (!w_dat) w_state_nx = ST_DATA;
        ST_DATA:   if (r_bitcnt == 3'd7) w_state_nx = ST_PARITY;
        ST_PARITY: w_state_nx = ST_STOP;
        ST_STOP: begin
          w_state_nx = ST_IDLE;
          if (w_dat && (^{r_sr, r_par})) w_good = 1'b1;
          else                           w_bad  = 1'b1;
        end
        default:   w_state_nx = ST_IDLE;
      endcase
    end else if ((r_state != ST_IDLE) && (r_to_cnt == TO_MAX)) begin
      w_state_nx = ST_IDLE;
      w_bad      = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_bus or negedge nreset) begin
    if (!nreset) r_state <= ST_IDLE;
    else         r_state <= w_state_nx;
  end

  // Frame datapath: bit counter, shift register, parity bit and timeout counter.
  always_ff @(posedge clk_bus or negedge nreset) begin
    if (!nreset) begin
      r_bitcnt <= 3'd0;
      r_sr     <= 8'd0;
      r_par    <= 1'b0;
      r_to_cnt <= 20'd0;
    end else begin
      if ((r_state == ST_IDLE) || w_fall) r_to_cnt <= 20'd0;
      else                                r_to_cnt <= r_to_cnt + 20'd1;
      if (w_fall) begin
        case (r_state)
          ST_IDLE:   r_bitcnt <= 3'd0;
          ST_DATA: begin
            r_sr     <= {w_dat, r_sr[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          ST_PARITY: r_par <= w_dat;
          default:   ;
        endcase
      end
    end
  end

`ifdef PS2_RX_FIFO_EN
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W:0]   r_count;
  logic             r_err;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = keyb_valid & keyb_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push = w_good & ((r_count != CNT_FULL) | w_pop);

  // Pointer and occupancy bookkeeping plus error pulse (frame error or overflow).
  always_ff @(posedge clk_bus or negedge nreset) begin
    if (!nreset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
      r_err   <= w_bad | (w_good & ~w_push);
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; entries are only read while r_count says they are valid.
  always_ff @(posedge clk_bus) begin
    if (w_push) r_mem[r_wr] <= r_sr;
  end

  assign keyb_valid = (r_count != '0);
  assign keyb_data  = keyb_valid ? r_mem[r_rd] : 8'h00;
  assign rx_err     = r_err;
`else
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_err;
  logic       w_unused_cfg;

  // Without the FIFO there is no backpressure; keyb_ready and FIFO_DEPTH have no role.
  assign w_unused_cfg = keyb_ready ^ (FIFO_DEPTH == 0);

  // Registered delivery: one-cycle valid pulse, data held until the next good byte.
  always_ff @(posedge clk_bus or negedge nreset) begin
    if (!nreset) begin
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_good;
      r_err   <= w_bad;
      if (w_good) r_data <= r_sr;
    end
  end

  assign keyb_data  = r_data;
  assign keyb_valid = r_valid;
  assign rx_err     = r_err;
`endif

endmodule
